// File: rtl/dcache_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | dcache_pkg : shared types, geometry constants and width helpers for dcache |
// | Revision   : 1.0                                                           |
// +----------------------------------------------------------------------------+
package dcache_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    FILL      = 2'd2
  } cacheState;

  localparam int LINE_BITS = 128;
  localparam int OFFSET_LO = 2;
  localparam int INDEX_LO  = 4;

  function automatic int indexBits(input int lines);
    return $clog2(lines);
  endfunction

  function automatic int tagBits(input int lines);
    return 32 - INDEX_LO - $clog2(lines);
  endfunction

endpackage
`default_nettype wire

// File: rtl/dcache_array.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | dcache_array : tag/valid/dirty/data storage, async read, sync word/line wr |
// | Revision     : 1.0                                                         |
// +----------------------------------------------------------------------------+
module dcache_array
  import dcache_pkg::*;
#(
  parameter int LINES = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [indexBits(LINES)-1:0] rdIndex,
  output logic                        rdValid,
  output logic                        rdDirty,
  output logic [tagBits(LINES)-1:0]   rdTag,
  output logic [LINE_BITS-1:0]        rdLine,
  input  logic [indexBits(LINES)-1:0] wrIndex,
  input  logic                        wordWe,
  input  logic [1:0]                  wordOffset,
  input  logic [31:0]                 wordData,
  input  logic                        lineWe,
  input  logic [tagBits(LINES)-1:0]   lineTag,
  input  logic [LINE_BITS-1:0]        lineData
);

  logic [LINE_BITS-1:0]      r_data [LINES];
  logic [tagBits(LINES)-1:0] r_tag  [LINES];
  logic [LINES-1:0]          r_valid;
  logic [LINES-1:0]          r_dirty;

  assign rdValid = r_valid[rdIndex];
  assign rdDirty = r_dirty[rdIndex];
  assign rdTag   = r_tag[rdIndex];
  assign rdLine  = r_data[rdIndex];

  // Payload arrays carry no reset; only the valid/dirty state is cleared.
  always_ff @(posedge clk) begin
    if (lineWe) begin
      r_data[wrIndex] <= lineData;
      r_tag[wrIndex]  <= lineTag;
    end else if (wordWe) begin
      r_data[wrIndex][{wordOffset, 5'b0} +: 32] <= wordData;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid <= '0;
      r_dirty <= '0;
    end else if (lineWe) begin
      r_valid[wrIndex] <= 1'b1;
      r_dirty[wrIndex] <= 1'b0;
    end else if (wordWe) begin
      r_dirty[wrIndex] <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/dcache.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | dcache : direct-mapped write-back write-allocate data cache               |
// |          optional DCACHE_STATS_EN builds hit/miss counters                 |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module dcache
  import dcache_pkg::*;
#(
  parameter int LINES = 16,
  parameter int WORDS = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic                 store,
  input  logic [31:0]          addr,
  input  logic [31:0]          wdata,
  output logic [31:0]          rdata,
  output logic                 dhit,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [31:0]          mem_addr,
  output logic [LINE_BITS-1:0] mem_wdata,
  input  logic                 mem_ready,
  input  logic [LINE_BITS-1:0] mem_rdata,
  output logic [31:0]          hit_count,
  output logic [31:0]          miss_count
);

  localparam int c_indexW = indexBits(LINES);
  localparam int c_tagW   = tagBits(LINES);
  localparam int c_offW   = $clog2(WORDS);

  cacheState             r_state, w_stateNext;
  logic [c_indexW-1:0]   w_reqIdx, r_missIdx, w_arrIdx;
  logic [c_tagW-1:0]     w_reqTag, r_missTag, w_rdTag;
  logic [c_offW-1:0]     w_offset;
  logic                  w_rdValid, w_rdDirty, w_hit, w_req, w_idle;
  logic [LINE_BITS-1:0]  w_rdLine;
  logic                  r_memReq, w_memReqNext, r_memWe, w_memWeNext;
  logic [31:0]           r_memAddr, w_memAddrNext;
  logic [LINE_BITS-1:0]  r_memWdata, w_memWdataNext;
  logic                  w_latchMiss, w_lineWe, w_wordWe;
  logic [1:0]            w_unusedAddr;

  assign w_unusedAddr = addr[1:0];
  assign w_offset = addr[OFFSET_LO +: c_offW];
  assign w_reqIdx = addr[INDEX_LO +: c_indexW];
  assign w_reqTag = addr[INDEX_LO + c_indexW +: c_tagW];
  assign w_req    = load | store;
  assign w_idle   = (r_state == IDLE);
  assign w_hit    = w_rdValid && (w_rdTag == w_reqTag);
  // Outside IDLE the array follows the latched miss line so the fill lands there.
  assign w_arrIdx = w_idle ? w_reqIdx : r_missIdx;

  dcache_array #(.LINES(LINES)) u_array (
    .clk        (clk),
    .reset      (reset),
    .rdIndex    (w_arrIdx),
    .rdValid    (w_rdValid),
    .rdDirty    (w_rdDirty),
    .rdTag      (w_rdTag),
    .rdLine     (w_rdLine),
    .wrIndex    (w_arrIdx),
    .wordWe     (w_wordWe),
    .wordOffset (w_offset),
    .wordData   (wdata),
    .lineWe     (w_lineWe),
    .lineTag    (r_missTag),
    .lineData   (mem_rdata)
  );

  assign rdata     = (w_idle && w_hit && load) ? w_rdLine[{w_offset, 5'b0} +: 32] : 32'd0;
  assign mem_req   = r_memReq;
  assign mem_we    = r_memWe;
  assign mem_addr  = r_memAddr;
  assign mem_wdata = r_memWdata;

  always_comb begin
    w_stateNext    = r_state;
    w_memReqNext   = r_memReq;
    w_memWeNext    = r_memWe;
    w_memAddrNext  = r_memAddr;
    w_memWdataNext = r_memWdata;
    w_latchMiss    = 1'b0;
    w_lineWe       = 1'b0;
    w_wordWe       = 1'b0;
    dhit           = 1'b1;
    case (r_state)
      IDLE: begin
        w_memReqNext = 1'b0;
        w_memWeNext  = 1'b0;
        if (w_req) begin
          if (w_hit) begin
            w_wordWe = store;
          end else begin
            dhit         = 1'b0;
            w_latchMiss  = 1'b1;
            w_memReqNext = 1'b1;
            if (w_rdValid && w_rdDirty) begin
              w_stateNext    = WRITEBACK;
              w_memWeNext    = 1'b1;
              w_memAddrNext  = {w_rdTag, w_reqIdx, 4'b0};
              w_memWdataNext = w_rdLine;
            end else begin
              w_stateNext   = FILL;
              w_memAddrNext = {w_reqTag, w_reqIdx, 4'b0};
            end
          end
        end
      end
      WRITEBACK: begin
        dhit = 1'b0;
        if (mem_ready) begin
          w_stateNext   = FILL;
          w_memWeNext   = 1'b0;
          w_memAddrNext = {r_missTag, r_missIdx, 4'b0};
        end
      end
      FILL: begin
        dhit = 1'b0;
        if (mem_ready) begin
          w_lineWe     = 1'b1;
          w_stateNext  = IDLE;
          w_memReqNext = 1'b0;
        end
      end
      default: w_stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_memReq   <= 1'b0;
      r_memWe    <= 1'b0;
      r_memAddr  <= '0;
      r_memWdata <= '0;
      r_missIdx  <= '0;
      r_missTag  <= '0;
    end else begin
      r_state    <= w_stateNext;
      r_memReq   <= w_memReqNext;
      r_memWe    <= w_memWeNext;
      r_memAddr  <= w_memAddrNext;
      r_memWdata <= w_memWdataNext;
      if (w_latchMiss) begin
        r_missIdx <= w_reqIdx;
        r_missTag <= w_reqTag;
      end
    end
  end

`ifdef DCACHE_STATS_EN
  logic [31:0] r_hitCount, r_missCount;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hitCount  <= '0;
      r_missCount <= '0;
    end else if (w_idle && w_req) begin
      if (w_hit) r_hitCount  <= r_hitCount + 32'd1;
      else       r_missCount <= r_missCount + 32'd1;
    end
  end

  assign hit_count  = r_hitCount;
  assign miss_count = r_missCount;
`else
  assign hit_count  = 32'd0;
  assign miss_count = 32'd0;
`endif

endmodule
`default_nettype wire

// File: doc/dcache.md
# dcache

Direct-mapped, write-back, write-allocate data cache that answers the processor's data-memory port (load/store requests, `dhit` stall signal, read data) and refills from a line-wide backing memory through a req/ready handshake. It sits between the core's memory-stage outputs and main memory. The core freezes its pipeline while `dhit` is low. Word-granular only; byte extraction stays in the core.

## Interface
Parameters:
- LINES, 16, number of cache lines; power of two, ≥2.
- WORDS, 4, 32-bit words per line; fixed at 4 (16-byte line).

Ports:
- clk  in  1  clock, rising-edge.
- reset  in  1  asynchronous, active-high.
- load  in  1  load request (core's `LoadM`).
- store  in  1  store request (core's `MemWrite`).
- addr  in  32  byte address (core's `ALUOut`); bits [1:0] ignored.
- wdata  in  32  store data.
- rdata  out  32  load data; valid when `dhit`=1 and `load`=1.
- dhit  out  1  1 = request satisfied this cycle, or no request.
- mem_req  out  1  backing-memory request.
- mem_we  out  1  1 = line write-back, 0 = line fill.
- mem_addr  out  32  line-aligned address; [3:0]=0.
- mem_wdata  out  128  victim line for write-back.
- mem_ready  in  1  memory completes the current transaction.
- mem_rdata  in  128  fill line; valid with `mem_ready`.
- hit_count  out  32  see Configuration.
- miss_count  out  32  see Configuration.

## Operation
- Address split: offset [3:2], index [3+log2(LINES):4], tag = remaining upper bits.
- States: IDLE, WRITEBACK, FILL.
- IDLE, no request: `dhit`=1, `mem_req`=0.
- IDLE, hit (valid && tag match): `dhit`=1 combinationally. Load → `rdata`=selected word. Store → word written and dirty set at the edge.
- IDLE, miss: `dhit`=0. Dirty victim → WRITEBACK; otherwise → FILL.
- WRITEBACK: `mem_req`=1, `mem_we`=1, `mem_addr`={victim tag, index, 4'b0}, `mem_wdata`=victim line. When `mem_ready` is sampled → FILL.
- FILL: `mem_req`=1, `mem_we`=0, `mem_addr`={request tag, index, 4'b0}. When `mem_ready` is sampled: line←`mem_rdata`, tag written, valid=1, dirty=0, → IDLE. The retried access then hits, and a store merges at that point.
- Miss address and tag are latched on entry to WRITEBACK/FILL. A core request dropped mid-miss does not abort the refill.
- `load` and `store` both high: treated as store.
- `rdata`=0 whenever not (IDLE && hit && load).

## Timing
- Hit: zero-latency `dhit`, single cycle.
- Clean miss: `dhit` low from the request cycle through the `mem_ready` cycle, and high the cycle after.
- Dirty miss: adds one full write-back transaction before the fill.
- Handshake: `mem_req`, `mem_we`, `mem_addr`, `mem_wdata` are registered and held stable until `mem_ready` is sampled high. `mem_req` drops the cycle after, except on WRITEBACK→FILL, where it stays high and `mem_we`/`mem_addr` change.
- `mem_ready` outside WRITEBACK/FILL is ignored.
- Reset, including mid-miss: state→IDLE, all valid and dirty bits→0, `mem_req`/`mem_we`=0, `mem_addr`/`mem_wdata`=0, counters=0, `dhit`=1 unless a request is present. The memory side must tolerate an abandoned transaction. Data and tag arrays are not cleared.

## Configuration
- DCACHE_STATS_EN defined: `hit_count` increments at every IDLE edge with a request and a hit, including the retry after a fill. `miss_count` increments on every IDLE→WRITEBACK/FILL transition. Both wrap modulo 2^32.
- DCACHE_STATS_EN undefined: both ports tied to 0 and no counter flops are built.

## Structure
- Package `dcache_pkg` holds:
  - state enum (IDLE, WRITEBACK, FILL)
  - LINE_BITS=128
  - OFFSET_LO=2, INDEX_LO=4
  - tag/index width helper functions derived from LINES
- Sub-module `dcache_array` holds the tag/valid/dirty/data storage, with:
  - one combinational read port indexed by the current index;
  - one synchronous write port supporting either a word write (store hit) or a full-line write (fill).
- The FSM, latches and counters stay in `dcache`.

## Test plan
- Cold load 0x100, memory model latency 3 returning line {0x4,0x3,0x2,0x1}: one FILL with `mem_addr`=0x100; `dhit` low 4 cycles; then `rdata`=0x1; `miss_count`=1, `hit_count`=1.
- Store 0xDEADBEEF to 0x104 after that fill: `dhit`=1 same cycle; a following load 0x104 returns 0xDEADBEEF and no `mem_req`.
- With LINES=16, load 0x1100 (same index, different tag) after the dirty line: WRITEBACK at 0x100 carries 0xDEADBEEF in word 1, then FILL at 0x1100.
- `mem_ready` held low 10 cycles during FILL: `mem_addr` stable, `dhit`=0 throughout; `load` dropped at cycle 5 and the fill still completes.
- Reset asserted during WRITEBACK: `mem_req`=0 immediately, `dhit`=1; the next load to 0x100 misses (valid cleared).
- Idle with no request: `dhit`=1, `mem_req`=0, counters unchanged; spurious `mem_ready` pulse ignored.
